accel_sequencer: RTL and testbench

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

---
 rtl/accel_pkg.sv | 54 +++++
 rtl/accel_sample_timer.sv | 30 +++
 rtl/accel_sequencer.sv | 147 ++++++++++++++
 tb/tb_accel_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants, packet layout and state encoding for the accelerometer sequencer.
// ACCEL_DEVID_CHECK_EN adds the device-ID check and ERROR states.
package accel_pkg;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  localparam logic [7:0] VAL_DATA_FORMAT = 8'h0C;
  localparam logic [7:0] VAL_BW_RATE     = 8'h0B;
  localparam logic [7:0] VAL_POWER_CTL   = 8'h08;
  localparam logic [7:0] DEVID           = 8'hE5;

  localparam int PKT_W        = 16;
  localparam int PKT_RW       = 15;
  localparam int PKT_MB       = 14;
  localparam int PKT_ADDR_LSB = 8;
  localparam int PKT_DATA_LSB = 0;
  localparam int INIT_WRITES  = 3;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd1,
    ST_SAMPLE   = 3'd2,
`ifdef ACCEL_DEVID_CHECK_EN
    ST_WAIT     = 3'd3,
    ST_CHECK_ID = 3'd0,
    ST_ERROR    = 3'd4
`else
    ST_WAIT     = 3'd3
`endif
  } state_t;

  function automatic logic [PKT_W-1:0] mk_pkt(input logic rw, input logic [5:0] addr,
                                              input logic [7:0] data);
    logic [PKT_W-1:0] p;
    p                     = '0;
    p[PKT_RW]             = rw;
    p[PKT_MB]             = 1'b0;
    p[PKT_ADDR_LSB +: 6]  = addr;
    p[PKT_DATA_LSB +: 8]  = data;
    return p;
  endfunction

  function automatic logic [PKT_W-1:0] init_pkt(input logic [1:0] i);
    case (i)
      2'd0:    return mk_pkt(1'b0, REG_DATA_FORMAT, VAL_DATA_FORMAT);
      2'd1:    return mk_pkt(1'b0, REG_BW_RATE, VAL_BW_RATE);
      default: return mk_pkt(1'b0, REG_POWER_CTL, VAL_POWER_CTL);
    endcase
  endfunction

endpackage

// File: rtl/accel_sample_timer.sv
// Inter-round wait counter: load a start value, count down to zero, pulse expire at zero.
module accel_sample_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic             run;

  assign expire = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/accel_sequencer.sv
// Drives a serial master through device init and periodic axis sampling.
// ACCEL_DEVID_CHECK_EN enables a device-ID read before init with a terminal ERROR state.
module accel_sequencer
  import accel_pkg::*;
#(
  parameter int NUM_AXES   = 2,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DIV = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       ack_i,
  input  logic [7:0]                 rx_byte_i,
  output logic                       req_o,
  output logic [PKT_W-1:0]           tx_pkt_o,
  output logic [NUM_AXES*DATA_W-1:0] axis_data_o,
  output logic                       data_valid_o,
  output logic                       init_done_o,
  output logic                       err_o
);

  localparam int          AW        = NUM_AXES * DATA_W;
  localparam int          NRD       = AW / 8;
  localparam logic [2:0]  LAST_RD   = 3'(NRD - 1);
  localparam logic [2:0]  INIT_LAST = 3'(INIT_WRITES - 1);
  localparam logic [19:0] DIV_LOAD  = (SAMPLE_DIV > 0) ? 20'(SAMPLE_DIV - 1) : 20'd0;
`ifdef ACCEL_DEVID_CHECK_EN
  localparam state_t FIRST_ST = ST_CHECK_ID;
`else
  localparam state_t FIRST_ST = ST_INIT;
`endif

  state_t           state, state_nx;
  logic [2:0]       idx, idx_nx;
  logic             idle;
  logic [AW-1:0]    shadow, shadow_nx;
  logic [PKT_W-1:0] pkt_nx;
  logic [5:0]       rd_addr;
  logic             issue, ack_ok, publish, tmr_load, tmr_expire;

  // 8-bit mode reads only the high byte of each axis register pair.
  always_comb begin
    if (DATA_W == 16) rd_addr = 6'(REG_DATAX0 + {3'b000, idx});
    else              rd_addr = 6'(REG_DATAX0 + 6'd1 + {2'b00, idx, 1'b0});
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    shadow_nx = shadow;
    pkt_nx    = '0;
    issue     = 1'b0;
    publish   = 1'b0;
    tmr_load  = 1'b0;
    ack_ok    = req_o && ack_i;
    case (state)
`ifdef ACCEL_DEVID_CHECK_EN
      ST_CHECK_ID: begin
        issue  = !req_o && !idle;
        pkt_nx = mk_pkt(1'b1, REG_DEVID, 8'h00);
        if (ack_ok) state_nx = (rx_byte_i == DEVID) ? ST_INIT : ST_ERROR;
      end
      ST_ERROR: state_nx = ST_ERROR;
`endif
      ST_INIT: begin
        issue  = !req_o && !idle;
        pkt_nx = init_pkt(idx[1:0]);
        if (ack_ok) begin
          if (idx == INIT_LAST) begin
            idx_nx   = '0;
            state_nx = ST_SAMPLE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      ST_SAMPLE: begin
        issue  = !req_o && !idle;
        pkt_nx = mk_pkt(1'b1, rd_addr, 8'h00);
        if (ack_ok) begin
          // Byte order on the wire matches byte order in the shadow word.
          for (int b = 0; b < NRD; b++)
            if (idx == 3'(b)) shadow_nx[8*b +: 8] = rx_byte_i;
          if (idx == LAST_RD) begin
            idx_nx  = '0;
            publish = 1'b1;
            if (SAMPLE_DIV > 0) begin
              tmr_load = 1'b1;
              state_nx = ST_WAIT;
            end
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      ST_WAIT: if (tmr_expire) state_nx = ST_SAMPLE;
      default: state_nx = FIRST_ST;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= FIRST_ST;
    else          state <= state_nx;
  end

  // idle holds off the first request one extra edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_o        <= 1'b0;
      tx_pkt_o     <= '0;
      idle         <= 1'b1;
      idx          <= '0;
      shadow       <= '0;
      axis_data_o  <= '0;
      data_valid_o <= 1'b0;
    end else begin
      idle         <= 1'b0;
      idx          <= idx_nx;
      shadow       <= shadow_nx;
      data_valid_o <= publish;
      if (publish) axis_data_o <= shadow_nx;
      if (ack_ok) begin
        req_o    <= 1'b0;
        tx_pkt_o <= '0;
      end else if (issue) begin
        req_o    <= 1'b1;
        tx_pkt_o <= pkt_nx;
      end
    end
  end

  accel_sample_timer #(.CNT_W(20)) u_timer (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .load     (tmr_load),
    .load_val (DIV_LOAD),
    .expire   (tmr_expire)
  );

  assign init_done_o = (state == ST_SAMPLE) || (state == ST_WAIT);
`ifdef ACCEL_DEVID_CHECK_EN
  assign err_o = (state == ST_ERROR);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench: dut_a (2 axes, 8 bit, no wait) and dut_b (3 axes, 16 bit, wait 10).
module tb_accel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack_a = 1'b0, ack_b = 1'b0;
  logic [7:0]  rx_a = '0, rx_b = '0;
  logic        req_a, req_b, val_a, val_b, ini_a, ini_b, err_a, err_b;
  logic [15:0] pkt_a, pkt_b;
  logic [15:0] axis_a;
  logic [47:0] axis_b;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  accel_sequencer #(.NUM_AXES(2), .DATA_W(8), .SAMPLE_DIV(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .ack_i(ack_a), .rx_byte_i(rx_a), .req_o(req_a),
    .tx_pkt_o(pkt_a), .axis_data_o(axis_a), .data_valid_o(val_a), .init_done_o(ini_a),
    .err_o(err_a));

  accel_sequencer #(.NUM_AXES(3), .DATA_W(16), .SAMPLE_DIV(10)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .ack_i(ack_b), .rx_byte_i(rx_b), .req_o(req_b),
    .tx_pkt_o(pkt_b), .axis_data_o(axis_b), .data_valid_o(val_b), .init_done_o(ini_b),
    .err_o(err_b));

  // Serve one transaction: wait for req, ack on its third cycle, return at the following negedge.
  task automatic xact(input int d, input logic [7:0] b, output logic [15:0] got, output bit to);
    to  = 1'b1;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      if ((d == 0 ? req_a : req_b) === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (to) return;
    got = (d == 0) ? pkt_a : pkt_b;
    repeat (2) @(negedge clk);
    if (d == 0) begin ack_a = 1'b1; rx_a = b; end
    else        begin ack_b = 1'b1; rx_b = b; end
    @(negedge clk);
    ack_a = 1'b0; ack_b = 1'b0; rx_a = '0; rx_b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({req_a, pkt_a, axis_a, val_a, ini_a, err_a} !== '0) begin
      errs++; $display("FAIL reset_a: got req=%b pkt=%h axis=%h val=%b ini=%b err=%b want all 0",
                       req_a, pkt_a, axis_a, val_a, ini_a, err_a); end
    checks++; if ({req_b, pkt_b, axis_b, val_b, ini_b, err_b} !== '0) begin
      errs++; $display("FAIL reset_b: got req=%b pkt=%h axis=%h want all 0", req_b, pkt_b, axis_b); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({req_a, req_b} !== 2'b00) begin
      errs++; $display("FAIL first_edge_req: got %b%b want 00", req_a, req_b); end
    @(negedge clk);
    checks++; if ({req_a, req_b} !== 2'b11) begin
      errs++; $display("FAIL second_edge_req: got %b%b want 11", req_a, req_b); end
  endtask

  task automatic test_init(input int d);
    logic [15:0] got;
    bit          to;
    logic [15:0] ep[3] = '{16'h310C, 16'h2C0B, 16'h2D08};
`ifdef ACCEL_DEVID_CHECK_EN
    xact(d, 8'hE5, got, to);
    checks++; if (to || got !== 16'h8000) begin
      errs++; $display("FAIL devid_pkt d%0d: got %h timeout=%0d want 8000", d, got, to); end
`endif
    for (int i = 0; i < 3; i++) begin
      checks++; if ((d == 0 ? ini_a : ini_b) !== 1'b0) begin
        errs++; $display("FAIL init_done_early d%0d w%0d: got 1 want 0", d, i); end
      xact(d, 8'h00, got, to);
      checks++; if (to || got !== ep[i]) begin
        errs++; $display("FAIL init_pkt d%0d w%0d: got %h timeout=%0d want %h", d, i, got, to, ep[i]); end
      checks++; if ((d == 0 ? {req_a, pkt_a} : {req_b, pkt_b}) !== 17'h0) begin
        errs++; $display("FAIL post_ack_idle d%0d w%0d: got req/pkt nonzero want 0", d, i); end
    end
    checks++; if ((d == 0 ? ini_a : ini_b) !== 1'b1) begin
      errs++; $display("FAIL init_done d%0d: got 0 want 1", d); end
  endtask

  task automatic test_sample_a();
    logic [15:0] got;
    bit          to;
    xact(0, 8'h11, got, to);
    checks++; if (to || got !== 16'hB300) begin
      errs++; $display("FAIL x_read_a: got %h want b300", got); end
    checks++; if (val_a !== 1'b0 || axis_a !== 16'h0000) begin
      errs++; $display("FAIL partial_a: got val=%b axis=%h want 0/0000", val_a, axis_a); end
    xact(0, 8'h22, got, to);
    checks++; if (to || got !== 16'hB500) begin
      errs++; $display("FAIL y_read_a: got %h want b500", got); end
    checks++; if (val_a !== 1'b1 || axis_a !== 16'h2211) begin
      errs++; $display("FAIL publish_a: got val=%b axis=%h want 1/2211", val_a, axis_a); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    bit          to;
    @(negedge clk);
    checks++; if (val_a !== 1'b0 || req_a !== 1'b1 || pkt_a !== 16'hB300 || axis_a !== 16'h2211) begin
      errs++; $display("FAIL b2b_restart: got val=%b req=%b pkt=%h axis=%h want 0/1/b300/2211",
                       val_a, req_a, pkt_a, axis_a); end
    xact(0, 8'hAA, got, to);
    xact(0, 8'h55, got, to);
    checks++; if (to || got !== 16'hB500 || val_a !== 1'b1 || axis_a !== 16'h55AA) begin
      errs++; $display("FAIL b2b_round: got pkt=%h val=%b axis=%h want b500/1/55aa", got, val_a, axis_a); end
  endtask

  task automatic test_wide();
    logic [15:0] got;
    bit          to;
    logic [7:0]  bytes[6] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    int          pulses = 0;
    for (int i = 0; i < 6; i++) begin
      xact(1, bytes[i], got, to);
      checks++; if (to || got !== (16'hB200 + 16'(i) * 16'h0100)) begin
        errs++; $display("FAIL wide_pkt%0d: got %h want %h", i, got, 16'hB200 + 16'(i) * 16'h0100); end
      if (val_b === 1'b1) pulses++;
    end
    checks++; if (axis_b !== 48'h9ABC_5678_1234) begin
      errs++; $display("FAIL wide_axis: got %h want 9abc56781234", axis_b); end
    checks++; if (pulses != 1 || val_b !== 1'b1) begin
      errs++; $display("FAIL wide_valid: got pulses=%0d val=%b want 1/1", pulses, val_b); end
  endtask

  task automatic test_wait();
    logic [15:0] got;
    bit          to;
    int          n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (req_b === 1'b1) break;
      ack_b = (n >= 2 && n <= 5);
      rx_b  = 8'hFF;
    end
    ack_b = 1'b0; rx_b = '0;
    checks++; if (n != 11) begin
      errs++; $display("FAIL wait_gap: got %0d cycles want 11", n); end
    for (int i = 0; i < 6; i++) begin
      xact(1, 8'(i + 1), got, to);
      checks++; if (to || got !== (16'hB200 + 16'(i) * 16'h0100)) begin
        errs++; $display("FAIL wait_round_pkt%0d: got %h want %h", i, got, 16'hB200 + 16'(i) * 16'h0100); end
    end
    checks++; if (val_b !== 1'b1 || axis_b !== 48'h0605_0403_0201) begin
      errs++; $display("FAIL wait_round_axis: got val=%b axis=%h want 1/060504030201", val_b, axis_b); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    bit          to;
    xact(0, 8'h77, got, to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_a === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++; if (to || pkt_a !== 16'hB500) begin
      errs++; $display("FAIL mid_y_pending: got req=%b pkt=%h want 1/b500", req_a, pkt_a); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req_a, pkt_a, axis_a, val_a, ini_a} !== '0) begin
      errs++; $display("FAIL mid_reset_zero: got req=%b pkt=%h axis=%h ini=%b want 0", req_a, pkt_a, axis_a, ini_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_init(0);
    xact(0, 8'h31, got, to);
    checks++; if (val_a !== 1'b0 || axis_a !== 16'h0000) begin
      errs++; $display("FAIL mid_no_partial: got val=%b axis=%h want 0/0000", val_a, axis_a); end
    xact(0, 8'h42, got, to);
    checks++; if (val_a !== 1'b1 || axis_a !== 16'h4231) begin
      errs++; $display("FAIL mid_new_round: got val=%b axis=%h want 1/4231", val_a, axis_a); end
  endtask

  task automatic test_devid();
`ifdef ACCEL_DEVID_CHECK_EN
    logic [15:0] got;
    bit          to;
    bit          seen = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 8'h00, got, to);
    checks++; if (to || got !== 16'h8000) begin
      errs++; $display("FAIL devid_bad_pkt: got %h want 8000", got); end
    checks++; if (err_a !== 1'b1 || ini_a !== 1'b0) begin
      errs++; $display("FAIL devid_err: got err=%b ini=%b want 1/0", err_a, ini_a); end
    repeat (100) begin
      @(negedge clk);
      if (req_a !== 1'b0 || err_a !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin
      errs++; $display("FAIL devid_terminal: got req or err change want req=0 err=1"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_init(0);
    checks++; if (err_a !== 1'b0) begin
      errs++; $display("FAIL devid_good_err: got %b want 0", err_a); end
`else
    checks++; if ({err_a, err_b} !== 2'b00) begin
      errs++; $display("FAIL err_tied: got %b%b want 00", err_a, err_b); end
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init(0);
    test_sample_a();
    test_init(1);
    test_wide();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    test_devid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
